// File: rtl/controlador_reabastecimento_rolhas_pkg.sv
// Shared state encoding, service-source codes and default sizing for the
// cork tray refill sequencer.
package controlador_rolhas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ARB  = 2'b01,
    ST_LOAD = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam logic SRC_OP   = 1'b0;
  localparam logic SRC_AUTO = 1'b1;

  localparam int DEF_WIDTH     = 7;
  localparam int DEF_MIN_LEVEL = 5;
  localparam int DEF_AUTO_QTY  = 20;
  localparam int DEF_MAX_LEVEL = 99;

endpackage

// File: rtl/controlador_reabastecimento_rolhas_detector.sv
// Rising-edge detector for the debounced operator request: pulse is high in
// the cycle where d is 1 and was 0 at the previous clock edge.
module detector_borda_subida
  import controlador_rolhas_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/controlador_reabastecimento_rolhas.sv
// Cork tray refill sequencer: arbitrates auto minimum-level refills against
// operator loads. Optional macro CTRL_ROLHAS_SAT_EN clamps operator overflow.
module controlador_reabastecimento_rolhas
  import controlador_rolhas_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MIN_LEVEL = DEF_MIN_LEVEL,
  parameter int AUTO_QTY  = DEF_AUTO_QTY,
  parameter int MAX_LEVEL = DEF_MAX_LEVEL
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             enable,
  input  logic             op_req,
  input  logic [WIDTH-1:0] op_qty,
  input  logic             ve,
  input  logic [WIDTH-1:0] tray_count,
  output logic             load,
  output logic [WIDTH-1:0] load_value,
  output logic             busy,
  output logic             src,
  output logic             done,
  output logic             rejected
`ifdef CTRL_ROLHAS_SAT_EN
  ,output logic            clamped
`endif
);

  if (MIN_LEVEL - 1 + AUTO_QTY > MAX_LEVEL) begin : g_bad_levels
    $error("auto refill from MIN_LEVEL-1 would exceed MAX_LEVEL");
  end
  if (MAX_LEVEL >= (1 << WIDTH)) begin : g_bad_width
    $error("MAX_LEVEL does not fit in WIDTH bits");
  end

  localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_LEVEL);
  localparam logic [WIDTH-1:0] AUTO_W = WIDTH'(AUTO_QTY);
  localparam logic [WIDTH:0]   MAX_S  = (WIDTH+1)'(MAX_LEVEL);

  state_t           state;
  logic [WIDTH-1:0] qty_r;
  logic             op_edge;
  logic             op_pend;
  logic             auto_req;
  logic [WIDTH:0]   op_sum;
  logic             op_over;
  logic             reject_now;
  logic [WIDTH-1:0] load_sum;

  detector_borda_subida u_borda (
    .clk   (clk),
    .clr   (clr),
    .d     (op_req),
    .pulse (op_edge)
  );

  assign auto_req = tray_count < MIN_W;
  assign op_sum   = {1'b0, tray_count} + {1'b0, op_qty};
  assign op_over  = op_sum > MAX_S;
  assign load_sum = tray_count + qty_r;

`ifdef CTRL_ROLHAS_SAT_EN
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_LEVEL);
  logic [WIDTH-1:0] clamp_qty;
  logic             clamp_r;
  assign clamp_qty  = (tray_count >= MAX_W) ? '0 : MAX_W - tray_count;
  assign reject_now = 1'b0;
`else
  assign reject_now = (state == ST_ARB) & enable & ~auto_req & op_pend & op_over;
`endif

  // Gated by enable so an abort cycle in LOAD can never strobe the buffer.
  assign load       = (state == ST_LOAD) & ~ve & enable;
  assign load_value = load ? load_sum : '0;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      op_pend <= 1'b0;
    else if (op_edge & enable)
      op_pend <= 1'b1;
    else if (~enable | reject_now | ((state == ST_DONE) & (src == SRC_OP)))
      op_pend <= 1'b0;
  end

  // Control FSM; busy tracks the next state so it lines up with the state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= ST_IDLE;
      qty_r    <= '0;
      src      <= SRC_OP;
      busy     <= 1'b0;
      done     <= 1'b0;
      rejected <= 1'b0;
`ifdef CTRL_ROLHAS_SAT_EN
      clamp_r  <= 1'b0;
      clamped  <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      rejected <= 1'b0;
`ifdef CTRL_ROLHAS_SAT_EN
      clamped  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (enable & (auto_req | op_pend)) begin
            state <= ST_ARB;
            busy  <= 1'b1;
          end
        end
        ST_ARB: begin
          if (~enable) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (auto_req) begin
            src   <= SRC_AUTO;
            qty_r <= AUTO_W;
            state <= ST_LOAD;
`ifdef CTRL_ROLHAS_SAT_EN
            clamp_r <= 1'b0;
`endif
          end else if (op_pend) begin
            src <= SRC_OP;
            if (op_over) begin
`ifdef CTRL_ROLHAS_SAT_EN
              clamp_r <= 1'b1;
              qty_r   <= clamp_qty;
              if (clamp_qty == '0) begin
                state   <= ST_DONE;
                done    <= 1'b1;
                clamped <= 1'b1;
              end else begin
                state <= ST_LOAD;
              end
`else
              rejected <= 1'b1;
              state    <= ST_IDLE;
              busy     <= 1'b0;
`endif
            end else begin
              qty_r <= op_qty;
`ifdef CTRL_ROLHAS_SAT_EN
              clamp_r <= 1'b0;
`endif
              if (op_qty == '0) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                state <= ST_LOAD;
              end
            end
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (~enable) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (~ve) begin
            state <= ST_DONE;
            done  <= 1'b1;
`ifdef CTRL_ROLHAS_SAT_EN
            clamped <= clamp_r;
`endif
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/controlador_reabastecimento_rolhas.md
# controlador_reabastecimento_rolhas

Sequencer for the cork tray buffer of the filling/sealing plant. It arbitrates between operator load requests and automatic minimum-level refills. It computes the new tray total, range-checks it against the 99-cork display limit, and issues a single load strobe to the tray buffer only in a cycle with no sealing decrement. It sits between the debounced operator inputs, the cork input counter, the sealing FSM `ve` output and the tray buffer's load port.

## Interface
Parameters:
- `WIDTH`, 7: tray and quantity width.
- `MIN_LEVEL`, 5: auto refill is requested while `tray_count < MIN_LEVEL`.
- `AUTO_QTY`, 20: corks added per auto refill.
- `MAX_LEVEL`, 99: tray ceiling.
- Constraint: `MIN_LEVEL - 1 + AUTO_QTY <= MAX_LEVEL`, checked at elaboration.

Ports:
- `clk` in 1: single clock, divided plant clock.
- `clr` in 1: reset, asynchronous, active-high.
- `enable` in 1: plant running (start_stop).
- `op_req` in 1: debounced operator load request, level.
- `op_qty` in WIDTH: corks counted at the input counter.
- `ve` in 1: sealing active; the tray decrements in this cycle.
- `tray_count` in WIDTH: current tray buffer content.
- `load` out 1: one-cycle load strobe to the tray buffer.
- `load_value` out WIDTH: new tray total; valid only while `load` = 1.
- `busy` out 1: FSM not in IDLE.
- `src` out 1: source of the current or last service; 0 = operator, 1 = auto.
- `done` out 1: one-cycle pulse when a service completes.
- `rejected` out 1: one-cycle pulse when an operator request is refused.

## Operation
- States: IDLE (reset), ARB, LOAD, DONE.
- `op_pend`:
  - Set on a rising edge of `op_req` while `enable` = 1. The edge is registered, so the first cycle `op_req` = 1 does not count.
  - One-deep: further edges while it is set are absorbed.
  - Cleared on completion or rejection of an operator service, and whenever `enable` = 0.
  - If set and clear fall in the same cycle, set wins.
- `auto_req` = `tray_count < MIN_LEVEL`, combinational.
- IDLE -> ARB when `enable` & (`auto_req` | `op_pend`).
- ARB (one cycle):
  - Source: auto has priority when both requests are present; the operator request stays pending.
  - Latch `qty_r`: `AUTO_QTY` for auto, or `op_qty` sampled in this cycle for operator.
  - Register `src`.
  - Sum is computed `WIDTH+1` bits wide: `tray_count + qty_r`.
  - Operator sum > `MAX_LEVEL`: see Configuration.
  - Operator with `op_qty` = 0: go to DONE with no load.
  - Otherwise go to LOAD.
- LOAD:
  - `load` = (state == LOAD) & ~`ve`. This is combinational, so it never coincides with a sealing decrement.
  - `load_value` = `tray_count + qty_r`, combinational from the live `tray_count`, so a decrement during the wait is included.
  - Stays in LOAD while `ve` = 1; moves to DONE after the `load` cycle.
- DONE: `done` = 1 for one cycle; clear the served request; go to IDLE. `auto_req` is re-evaluated on the updated `tray_count`.
- `enable` falling in ARB or LOAD: abort to IDLE with no `load` and no `done`; `op_pend` is cleared.
- `clr` mid-operation: immediate return to IDLE with all outputs at reset values.

## Timing
- Reset values: `load` = 0, `load_value` = 0, `busy` = 0, `src` = 0, `done` = 0, `rejected` = 0, state = IDLE, `op_pend` = 0.
- Latency from request to load, `ve` low: request visible in IDLE -> ARB +1 -> LOAD +2 (`load` high) -> DONE +3.
- Each cycle of `ve` = 1 in LOAD adds one cycle.
- Exactly one `load` per accepted service.
- `busy` is a registered decode of the state.
- `done` and `rejected` are registered pulses.
- Back-to-back services have at least one IDLE cycle between them.

## Configuration
- `CTRL_ROLHAS_SAT_EN` defined:
  - An operator sum > `MAX_LEVEL` is clamped: `qty_r` = `MAX_LEVEL - tray_count`; go to LOAD.
  - If that clamped value is 0, go to DONE with no load.
  - Adds output `clamped` (out 1), pulsed in DONE for a clamped service; reset value 0.
- Undefined:
  - An operator sum > `MAX_LEVEL` gives `rejected` = 1 in the cycle after ARB, clears `op_pend` and returns to IDLE.
  - No load and no `done`.
  - The `clamped` port does not exist.

## Structure
- Package `controlador_rolhas_pkg`: state encoding (2-bit, IDLE = 00), `SRC_OP`/`SRC_AUTO` constants, default `WIDTH`/`MIN_LEVEL`/`AUTO_QTY`/`MAX_LEVEL` values.
- Sub-module `detector_borda_subida` (`clk`, `clr`, `d` -> `pulse`) for the `op_req` edge.

## Test plan
- Auto refill: `enable` = 1, `tray_count` = 3, `ve` = 0 -> ARB, then LOAD with `load` = 1, `load_value` = 23, `src` = 1, then `done`.
- Operator request: `tray_count` = 40, `op_qty` = 30, rising edge of `op_req` -> `load_value` = 70, `src` = 0.
- Seal collision: `ve` = 1 for 3 cycles during LOAD, `tray_count` going 40 -> 39 -> 38 -> 37, `op_qty` = 10 -> no `load` while `ve` = 1; single `load` with `load_value` = 47.
- Simultaneous requests: `tray_count` = 2 and an operator edge in the same cycle -> auto served first (`load_value` = 22); operator served next with `tray_count` = 22.
- Overflow: `tray_count` = 90, `op_qty` = 20.
  - Without `CTRL_ROLHAS_SAT_EN`: `rejected` pulse, no `load`.
  - With it: `load_value` = 99, `clamped` pulse.
- Abort: `enable` dropped, or `clr` asserted, while in LOAD with `ve` = 1 -> IDLE, no `load`, `busy` = 0, `op_pend` cleared.
